// File: rtl/run_length_detector.sv
`default_nettype none
// ============================================================================
// Module      : run_length_detector
// Description : Serial run-length detector. Tracks the length of the current
//               run of equal samples on w and flags a detection once a run of
//               ones or zeros reaches RUN_LEN samples. Detection overlaps: the
//               block stays in its HIT state while the run continues. A mode
//               mask selects which run polarity is reported on z and counted
//               in det_count. det_count counts runs, not cycles, and
//               saturates at its maximum value.
//
//   Ports:
//     clock     in   1      rising-edge clock
//     reset     in   1      asynchronous active-high reset
//     en        in   1      sample enable
//     w         in   1      serial data sample
//     mode      in   2      00 ones+zeros, 01 ones, 10 zeros, 11 none
//     state     out  3      registered FSM state code
//     run_len   out  4      length of the current run (saturates at 15)
//     z         out  1      detection flag (decode of state and mode)
//     det_count out  DET_W  qualified detections since reset (saturating)
//
// Revision    : 1.0 - initial release
// ============================================================================
module run_length_detector #(
    parameter int RUN_LEN = 4,
    parameter int DET_W   = 8
) (
    input  logic             clock,
    input  logic             reset,
    input  logic             en,
    input  logic             w,
    input  logic [1:0]       mode,
    output logic [2:0]       state,
    output logic [3:0]       run_len,
    output logic             z,
    output logic [DET_W-1:0] det_count
);

    localparam logic [2:0] c_IDLE = 3'b000;
    localparam logic [2:0] c_RUN1 = 3'b001;
    localparam logic [2:0] c_RUN0 = 3'b010;
    localparam logic [2:0] c_HIT1 = 3'b011;
    localparam logic [2:0] c_HIT0 = 3'b100;

    localparam logic [3:0] c_LEN_MAX = 4'd15;
    localparam logic [3:0] c_RUN_LEN = 4'(RUN_LEN);

    logic [2:0]       r_state;
    logic [3:0]       r_run_len;
    logic [DET_W-1:0] r_det_count;

    logic [2:0]       w_next_state;
    logic [3:0]       w_next_len;
    logic [3:0]       w_len_inc;
    logic             w_enter_hit;

    assign w_len_inc = (r_run_len == c_LEN_MAX) ? c_LEN_MAX : r_run_len + 4'd1;

    always_comb begin
        w_next_state = r_state;
        w_next_len   = r_run_len;
        case (r_state)
            c_IDLE: begin
                w_next_state = w ? c_RUN1 : c_RUN0;
                w_next_len   = 4'd1;
            end
            c_RUN1, c_HIT1: begin
                if (w) begin
                    w_next_len   = w_len_inc;
                    w_next_state = (w_len_inc >= c_RUN_LEN) ? c_HIT1 : c_RUN1;
                end else begin
                    w_next_len   = 4'd1;
                    w_next_state = c_RUN0;
                end
            end
            c_RUN0, c_HIT0: begin
                if (!w) begin
                    w_next_len   = w_len_inc;
                    w_next_state = (w_len_inc >= c_RUN_LEN) ? c_HIT0 : c_RUN0;
                end else begin
                    w_next_len   = 4'd1;
                    w_next_state = c_RUN1;
                end
            end
            default: begin
                // Unused codes recover to IDLE with no run in progress.
                w_next_state = c_IDLE;
                w_next_len   = 4'd0;
            end
        endcase
    end

    // A detection is a fresh entry into a HIT state whose polarity the mode
    // at this edge enables; staying in HIT while the run continues does not
    // count again.
    assign w_enter_hit = ((w_next_state == c_HIT1) && (r_state != c_HIT1) && !mode[1]) ||
                         ((w_next_state == c_HIT0) && (r_state != c_HIT0) && !mode[0]);

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state     <= c_IDLE;
            r_run_len   <= 4'd0;
            r_det_count <= '0;
        end else if (en) begin
            r_state   <= w_next_state;
            r_run_len <= w_next_len;
            if (w_enter_hit && (r_det_count != {DET_W{1'b1}})) begin
                r_det_count <= r_det_count + 1'b1;
            end
        end
    end

    assign state     = r_state;
    assign run_len   = r_run_len;
    assign det_count = r_det_count;

    // z depends on the registered state and the live mode only.
    assign z = ((r_state == c_HIT1) && !mode[1]) ||
               ((r_state == c_HIT0) && !mode[0]);

endmodule
`default_nettype wire

// File: tb/tb_run_length_detector.sv
`default_nettype none
// ============================================================================
// Module      : tb_run_length_detector
// Description : Self-checking bench for run_length_detector. Two instances
//               (DET_W=8 and DET_W=2) share stimulus; a behavioural model
//               tracks the current run as a last bit plus an unbounded count.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_run_length_detector;

    localparam int c_RUN_LEN = 4;

    logic       clock;
    logic       reset;
    logic       en;
    logic       w;
    logic [1:0] mode;

    logic [2:0] state_a, state_b;
    logic [3:0] run_len_a, run_len_b;
    logic       z_a, z_b;
    logic [7:0] det_a;
    logic [1:0] det_b;

    int n_cmp = 0;
    int n_err = 0;

    // behavioural model: last sample, raw length of current run, det counts
    bit m_valid;
    bit m_bit;
    int m_cnt;
    int m_det_a;
    int m_det_b;

    run_length_detector #(.RUN_LEN(c_RUN_LEN), .DET_W(8)) u_dut_a (
        .clock(clock), .reset(reset), .en(en), .w(w), .mode(mode),
        .state(state_a), .run_len(run_len_a), .z(z_a), .det_count(det_a)
    );

    run_length_detector #(.RUN_LEN(c_RUN_LEN), .DET_W(2)) u_dut_b (
        .clock(clock), .reset(reset), .en(en), .w(w), .mode(mode),
        .state(state_b), .run_len(run_len_b), .z(z_b), .det_count(det_b)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d (t=%0t)", tag, got, exp, $time);
        end
    endtask

    function automatic bit qualifies(input bit b, input logic [1:0] md);
        return b ? (md == 2'b00 || md == 2'b01) : (md == 2'b00 || md == 2'b10);
    endfunction

    function automatic int exp_state();
        if (!m_valid) return 0;
        if (m_cnt >= c_RUN_LEN) return m_bit ? 3 : 4;
        return m_bit ? 1 : 2;
    endfunction

    function automatic int exp_len();
        if (!m_valid) return 0;
        return (m_cnt > 15) ? 15 : m_cnt;
    endfunction

    function automatic int exp_z();
        return (m_valid && m_cnt >= c_RUN_LEN && qualifies(m_bit, mode)) ? 1 : 0;
    endfunction

    task automatic model_clear();
        m_valid = 0; m_bit = 0; m_cnt = 0; m_det_a = 0; m_det_b = 0;
    endtask

    task automatic model_edge();
        if (!en) return;
        if (!m_valid || (w != m_bit)) begin
            m_valid = 1; m_bit = w; m_cnt = 1;
        end else begin
            m_cnt++;
        end
        if (m_cnt == c_RUN_LEN && qualifies(m_bit, mode)) begin
            if (m_det_a < 255) m_det_a++;
            if (m_det_b < 3)   m_det_b++;
        end
    endtask

    task automatic check_all(input string tag);
        chk({tag, ".state"},   int'(state_a),   exp_state());
        chk({tag, ".run_len"}, int'(run_len_a), exp_len());
        chk({tag, ".z"},       int'(z_a),       exp_z());
        chk({tag, ".det"},     int'(det_a),     m_det_a);
        chk({tag, ".det_b"},   int'(det_b),     m_det_b);
        chk({tag, ".state_b"}, int'(state_b),   exp_state());
    endtask

    // One clock edge with the currently driven inputs, checked 1ns after.
    task automatic step(input string tag);
        model_edge();
        @(posedge clock);
        #1;
        check_all(tag);
    endtask

    // Reset pulse placed between edges; outputs must clear immediately.
    task automatic pulse_reset(input string tag);
        reset = 1'b1;
        #1;
        model_clear();
        chk({tag, ".rst_state"}, int'(state_a),   0);
        chk({tag, ".rst_len"},   int'(run_len_a), 0);
        chk({tag, ".rst_z"},     int'(z_a),       0);
        chk({tag, ".rst_det"},   int'(det_a),     0);
        reset = 1'b0;
    endtask

    initial begin
        reset = 1'b1; en = 1'b0; w = 1'b0; mode = 2'b00;
        model_clear();
        #2;
        chk("por.state", int'(state_a), 0);
        chk("por.z",     int'(z_a),     0);
        chk("por.det",   int'(det_a),   0);
        #10;
        reset = 1'b0;

        // six ones, mode 00: z rises after the 4th edge
        en = 1'b1; w = 1'b1; mode = 2'b00;
        for (int i = 1; i <= 6; i++) begin
            step("ones6");
            chk("ones6.z_const",   int'(z_a),       (i >= 4) ? 1 : 0);
            chk("ones6.len_const", int'(run_len_a), i);
        end
        chk("ones6.state_const", int'(state_a), 3);
        chk("ones6.det_const",   int'(det_a),   1);

        // 1,1,1,0,0,0,0 : z only after 7th edge, HIT0
        pulse_reset("p2");
        for (int i = 1; i <= 7; i++) begin
            w = (i <= 3);
            step("p2");
            chk("p2.z_const", int'(z_a), (i == 7) ? 1 : 0);
        end
        chk("p2.state_const", int'(state_a), 4);
        chk("p2.det_const",   int'(det_a),   1);

        // mode 01 with four zeros: hidden, not counted; then mode 00 at once
        pulse_reset("p3");
        mode = 2'b01; w = 1'b0;
        repeat (4) step("p3");
        chk("p3.z_hidden",  int'(z_a),     0);
        chk("p3.det_hidden", int'(det_a),  0);
        mode = 2'b00;
        #1;
        chk("p3.z_now",   int'(z_a),     1);
        chk("p3.det_now", int'(det_a),   0);
        chk("p3.state",   int'(state_a), 4);

        // enable gaps do not break the run
        pulse_reset("p4");
        w = 1'b1; en = 1'b1;
        repeat (2) step("p4a");
        en = 1'b0; w = 1'b0;
        for (int i = 0; i < 3; i++) begin
            step("p4hold");
            chk("p4hold.len_const", int'(run_len_a), 2);
        end
        en = 1'b1; w = 1'b1;
        step("p4b");
        chk("p4b.z3", int'(z_a), 0);
        step("p4b");
        chk("p4b.z4", int'(z_a), 1);

        // reset mid-run discards partial run
        pulse_reset("p5");
        w = 1'b1;
        repeat (3) step("p5a");
        pulse_reset("p5mid");
        repeat (3) step("p5b");
        chk("p5b.z", int'(z_a), 0);
        step("p5c");
        chk("p5c.z",   int'(z_a),   1);
        chk("p5c.det", int'(det_a), 1);

        // 20 ones: run_len saturates at 15, one detection
        pulse_reset("p6");
        w = 1'b1;
        for (int i = 1; i <= 20; i++) begin
            step("p6");
            if (i >= 4) chk("p6.z_const", int'(z_a), 1);
        end
        chk("p6.len_const", int'(run_len_a), 15);
        chk("p6.det_const", int'(det_a),     1);

        // five separated qualified runs: DET_W=2 instance saturates at 3
        pulse_reset("p7");
        for (int r = 0; r < 5; r++) begin
            w = 1'b1; repeat (4) step("p7");
            w = 1'b0; step("p7");
        end
        chk("p7.det_a_const", int'(det_a), 5);
        chk("p7.det_b_const", int'(det_b), 3);

        // randomized traffic against the model
        pulse_reset("rnd");
        for (int i = 0; i < 600; i++) begin
            if ($urandom_range(0, 99) < 2) pulse_reset("rnd");
            en = ($urandom_range(0, 9) < 8);
            if ($urandom_range(0, 3) == 0) w = ~w;
            if ($urandom_range(0, 19) == 0) begin
                mode = 2'($urandom_range(0, 3));
                #1;
                chk("rnd.z_mode", int'(z_a), exp_z());
            end
            step("rnd");
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire
